// File: rtl/maxpool_pkg.sv
// Shared types and helpers for the 2x2 max-pooling datapath.
package maxpool_pkg;

  localparam int PIX_W = 8;

  typedef logic [PIX_W-1:0] pix_t;

  typedef enum logic [1:0] {
    ACCEPT,
    MERGE,
    OUT
  } state_t;

  // Unsigned max; on a tie the first operand wins.
  function automatic pix_t max2(input pix_t a, input pix_t b);
    return (b > a) ? b : a;
  endfunction

endpackage

// File: rtl/max2_unit.sv
// Combinational unsigned 2-input max; a tie returns a_i.
module max2_unit
  import maxpool_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] y_o
);

  assign y_o = (b_i > a_i) ? b_i : a_i;

endmodule

// File: rtl/maxpool2x2_seq.sv
// Streaming 2x2 stride-2 max pooling with one shared comparator and a half-width line buffer.
//
// state  | meaning
// ACCEPT | taking pixels; folds each pixel into hold or the line buffer
// MERGE  | combines buffered top-row max with bottom-row max into out_data
// OUT    | presents the pooled pixel until downstream accepts it
module maxpool2x2_seq
  import maxpool_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LD = IMG_W / 2;
  localparam int IW = (LD > 1) ? $clog2(LD) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  state_t              state_q, state_d;
  logic [CW-1:0]       col_q, col_d;
  logic [RW-1:0]       row_q, row_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                last_q, last_d;
  logic [DATA_W-1:0]   lbuf_q [LD];

  logic                lbuf_we;
  logic [IW-1:0]       lbuf_wa;
  logic                in_fire;
  logic [DATA_W-1:0]   cmp_a, cmp_b, cmp_y;

  // The comparator is steered by state: pixel vs hold while accepting, buffer vs hold while merging.
  assign cmp_a = (state_q == MERGE) ? lbuf_q[idx_q] : hold_q;
  assign cmp_b = (state_q == MERGE) ? hold_q : in_data;

  max2_unit #(.DATA_W(DATA_W)) u_max2 (
    .a_i (cmp_a),
    .b_i (cmp_b),
    .y_o (cmp_y)
  );

  assign in_fire = in_valid & in_ready_q;

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    hold_d      = hold_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    idx_d       = idx_q;
    last_d      = last_q;
    lbuf_we     = 1'b0;
    lbuf_wa     = IW'(col_q >> 1);

    case (state_q)
      ACCEPT: begin
        if (in_fire) begin
          if (!col_q[0]) begin
            hold_d = in_data;
          end else if (!row_q[0]) begin
            lbuf_we = 1'b1;
          end else begin
            hold_d  = cmp_y;
            idx_d   = lbuf_wa;
            last_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
            state_d = MERGE;
          end
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      MERGE: begin
        out_data_d  = cmp_y;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCEPT;
        end
      end
      default: state_d = ACCEPT;
    endcase

    in_ready_d = (state_d == ACCEPT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCEPT;
      col_q       <= '0;
      row_q       <= '0;
      hold_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      idx_q       <= '0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      hold_q      <= hold_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
    end
  end

  // Always written on an even row before the odd row reads it, so no reset needed.
  always_ff @(posedge clk) begin
    if (lbuf_we) lbuf_q[lbuf_wa] <= cmp_y;
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_done = (state_q == OUT) & out_ready & last_q;

endmodule

// File: tb/tb_maxpool2x2_seq.sv
// Bench for maxpool2x2_seq: a 4x2 and an 8x8 instance share stimulus, selected by sel.
module tb_maxpool2x2_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       out_ready = 1'b1;
  bit         sel = 1'b0;

  logic       rdy_a, ov_a, fd_a, rdy_b, ov_b, fd_b;
  logic [7:0] od_a, od_b;
  logic       in_ready, out_valid, frame_done;
  logic [7:0] out_data;

  maxpool2x2_seq #(.DATA_W(8), .IMG_W(4), .IMG_H(2)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid & ~sel), .in_data(in_data),
    .in_ready(rdy_a), .out_valid(ov_a), .out_data(od_a),
    .out_ready(out_ready), .frame_done(fd_a)
  );

  maxpool2x2_seq #(.DATA_W(8), .IMG_W(8), .IMG_H(8)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid & sel), .in_data(in_data),
    .in_ready(rdy_b), .out_valid(ov_b), .out_data(od_b),
    .out_ready(out_ready), .frame_done(fd_b)
  );

  assign in_ready   = sel ? rdy_b : rdy_a;
  assign out_valid  = sel ? ov_b : ov_a;
  assign out_data   = sel ? od_b : od_a;
  assign frame_done = sel ? fd_b : fd_a;

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int got[$];
  int exp_q[$];
  int fd_cnt = 0;
  int fd_bad = 0;

  // Record every accepted output; transfers happen at the following rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) got.push_back(int'(out_data));
      if (frame_done) begin
        fd_cnt++;
        if (!(out_valid && out_ready)) fd_bad++;
      end
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Golden model: max of each 2x2 window, windows in row-major order.
  task automatic pool_model(input int w, input int h, input int px[$]);
    for (int r = 0; r < h; r += 2)
      for (int c = 0; c < w; c += 2) begin
        int m = px[r*w + c];
        if (px[r*w + c + 1] > m) m = px[r*w + c + 1];
        if (px[(r+1)*w + c] > m) m = px[(r+1)*w + c];
        if (px[(r+1)*w + c + 1] > m) m = px[(r+1)*w + c + 1];
        exp_q.push_back(m);
      end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the pixel was taken.
  task automatic drive_pixel(input int p, input bit gaps);
    bit took;
    int n;
    int g;
    g = 0;
    while (gaps && g < 6 && $urandom_range(0, 1) == 0) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
      g++;
    end
    in_valid = 1'b1;
    in_data  = 8'(p);
    took = 1'b0;
    n = 0;
    while (!took && n < 50) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk); #1;
      n++;
    end
    check("in_xfer", int'(took), 1);
  endtask

  task automatic run_pixels(input int px[$], input bit gaps);
    foreach (px[i]) drive_pixel(px[i], gaps);
    in_valid = 1'b0;
  endtask

  task automatic expect_outputs(input string tag, input int nfd);
    int n;
    n = 0;
    while (got.size() < exp_q.size() && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (8) begin
      @(posedge clk); #1;
    end
    check({tag, "_count"}, got.size(), exp_q.size());
    foreach (exp_q[i])
      check($sformatf("%s_out%0d", tag, i), (i < got.size()) ? got[i] : -1, exp_q[i]);
    check({tag, "_frame_done"}, fd_cnt, nfd);
    check({tag, "_fd_align"}, fd_bad, 0);
    got.delete();
    exp_q.delete();
    fd_cnt = 0;
    fd_bad = 0;
  endtask

  initial begin
    int px[$];
    int n;

    // Reset state of both instances.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = bit'(s);
      #1;
      check($sformatf("rst_in_ready%0d", s), int'(in_ready), 0);
      check($sformatf("rst_out_valid%0d", s), int'(out_valid), 0);
      check($sformatf("rst_out_data%0d", s), int'(out_data), 0);
      check($sformatf("rst_frame_done%0d", s), int'(frame_done), 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    sel = 1'b0;
    @(posedge clk); #1;

    // Basic 4x2 frame.
    px = '{1, 5, 2, 3, 4, 0, 9, 7};
    pool_model(4, 2, px);
    run_pixels(px, 1'b0);
    expect_outputs("basic", 1);

    // Ties and extremes.
    px = '{255, 255, 0, 0, 255, 0, 0, 0};
    pool_model(4, 2, px);
    run_pixels(px, 1'b0);
    expect_outputs("extreme", 1);

    px = '{7, 7, 7, 7, 7, 7, 7, 7};
    pool_model(4, 2, px);
    run_pixels(px, 1'b0);
    expect_outputs("equal", 1);

    // Backpressure on the first result.
    px = '{1, 5, 2, 3, 4, 0, 9, 7};
    pool_model(4, 2, px);
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) drive_pixel(px[i], 1'b0);
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 10);
    for (int i = 0; i < 5; i++) begin
      check("stall_out_valid", int'(out_valid), 1);
      check("stall_out_data", int'(out_data), exp_q[0]);
      check("stall_in_ready", int'(in_ready), 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive_pixel(px[6], 1'b0);
    drive_pixel(px[7], 1'b0);
    in_valid = 1'b0;
    expect_outputs("stall", 1);

    // Mid-frame reset on the 8x8 instance, then a clean random frame with input gaps.
    sel = 1'b1;
    for (int i = 0; i < 3; i++) drive_pixel(int'($urandom_range(0, 255)), 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_in_ready", int'(in_ready), 0);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_data", int'(out_data), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rel_in_ready_low", int'(in_ready), 0);
    @(negedge clk);
    check("rel_in_ready_high", int'(in_ready), 1);
    @(posedge clk); #1;
    got.delete();
    fd_cnt = 0;
    fd_bad = 0;
    px.delete();
    for (int i = 0; i < 64; i++) px.push_back(int'($urandom_range(0, 255)));
    pool_model(8, 8, px);
    run_pixels(px, 1'b1);
    expect_outputs("rand8x8", 1);

    // Two back-to-back 4x2 frames with very different value ranges.
    sel = 1'b0;
    @(posedge clk); #1;
    px.delete();
    for (int i = 0; i < 8; i++) px.push_back(int'($urandom_range(200, 255)));
    pool_model(4, 2, px);
    begin
      int px2[$];
      for (int i = 0; i < 8; i++) px2.push_back(int'($urandom_range(0, 50)));
      pool_model(4, 2, px2);
      px = {px, px2};
    end
    run_pixels(px, 1'b0);
    expect_outputs("b2b", 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
